// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS control unit: opcodes, ALU
// operation codes, FSM state encoding and the opcode support check.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_R    = 6'd0;
  localparam logic [5:0] OP_LW   = 6'd35;
  localparam logic [5:0] OP_SW   = 6'd43;
  localparam logic [5:0] OP_BEQ  = 6'd4;
  localparam logic [5:0] OP_ADDI = 6'd8;
  localparam logic [5:0] OP_J    = 6'd2;

  localparam int ALU_NONE  = 0;
  localparam int ALU_RTYPE = 1;
  localparam int ALU_ADD   = 2;
  localparam int ALU_SUB   = 3;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_MEM_ADDR = 4'd3,
    S_MEM_RD   = 4'd4,
    S_MEM_WB   = 4'd5,
    S_MEM_WR   = 4'd6,
    S_EXEC     = 4'd7,
    S_R_WB     = 4'd8,
    S_BRANCH   = 4'd9,
    S_JUMP     = 4'd10,
    S_ADDI_EX  = 4'd11,
    S_ADDI_WB  = 4'd12,
    S_ERROR    = 4'd13
  } state_t;

  // True when the opcode has a decode path in this build of the unit.
  function automatic logic op_supported(input logic [5:0] op, input logic en_addi,
                                        input logic en_jump);
    return (op == OP_R) || (op == OP_LW) || (op == OP_SW) || (op == OP_BEQ) ||
           ((op == OP_ADDI) && en_addi) || ((op == OP_J) && en_jump);
  endfunction

endpackage

// File: rtl/mips_mem_watchdog.sv
// Memory wait watchdog: counts cycles spent stalled on mem_ready within one
// memory state and flags when the count reaches MEM_TIMEOUT (0 disables it).
module mips_mem_watchdog #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic wait_cyc,
  output logic expired
);

  localparam int CNT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;

  logic [CNT_W-1:0] count;

  // Wait counter: cleared whenever the FSM changes state, saturates once expired.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (wait_cyc && !expired) begin
      count <= count + CNT_W'(1);
    end
  end

  assign expired = (MEM_TIMEOUT != 0) && (count == CNT_W'(MEM_TIMEOUT));

endmodule

// File: rtl/mips_multicycle_control.sv
// Multicycle MIPS control FSM: sequences fetch, decode, execute, memory and
// write-back, drives every datapath select/enable and stalls on mem_ready.
module mips_multicycle_control #(
  parameter int ALUOP_W     = 3,
  parameter int MEM_TIMEOUT = 16,
  parameter int EN_ADDI     = 1,
  parameter int EN_JUMP     = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [5:0]         op,
  input  logic               mem_ready,
  output logic               pc_write,
  output logic               pc_write_cond,
  output logic               iord,
  output logic               mem_read,
  output logic               mem_write,
  output logic               ir_write,
  output logic               mem_to_reg,
  output logic               reg_write,
  output logic               reg_dst,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [ALUOP_W-1:0] alu_op,
  output logic [1:0]         pc_source,
  output logic               illegal_op,
  output logic               mem_err,
  output logic [3:0]         state_o
);

  import mips_ctrl_pkg::*;

  state_t state, next_state;
  logic   wd_clr, wd_wait, wd_expired;

  assign wd_clr  = (next_state != state);
  assign wd_wait = ((state == S_FETCH) || (state == S_MEM_RD) || (state == S_MEM_WR)) && !mem_ready;

  mips_mem_watchdog #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_watchdog (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (wd_clr),
    .wait_cyc (wd_wait),
    .expired  (wd_expired)
  );

  // State register; reset aborts any instruction in flight back to IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state decode and Moore outputs; only FETCH strobes and illegal_op see inputs.
  always_comb begin
    next_state    = state;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_write     = 1'b0;
    reg_dst       = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'd0;
    alu_op        = ALUOP_W'(ALU_NONE);
    pc_source     = 2'd0;
    illegal_op    = 1'b0;
    mem_err       = 1'b0;
    case (state)
      S_IDLE: next_state = S_FETCH;
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'd1;
        alu_op    = ALUOP_W'(ALU_ADD);
        ir_write  = mem_ready;
        pc_write  = mem_ready;
        if (mem_ready)       next_state = S_DECODE;
        else if (wd_expired) next_state = S_ERROR;
      end
      S_DECODE: begin
        alu_src_b = 2'd3;
        alu_op    = ALUOP_W'(ALU_ADD);
        if (!op_supported(op, EN_ADDI != 0, EN_JUMP != 0)) begin
          illegal_op = 1'b1;
          next_state = S_FETCH;
        end else if (op == OP_R)                     next_state = S_EXEC;
        else if ((op == OP_LW) || (op == OP_SW))    next_state = S_MEM_ADDR;
        else if (op == OP_BEQ)                      next_state = S_BRANCH;
        else if (op == OP_ADDI)                     next_state = S_ADDI_EX;
        else                                        next_state = S_JUMP;
      end
      S_MEM_ADDR: begin
        alu_src_a  = 1'b1;
        alu_src_b  = 2'd2;
        alu_op     = ALUOP_W'(ALU_ADD);
        next_state = (op == OP_SW) ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
        if (mem_ready)       next_state = S_MEM_WB;
        else if (wd_expired) next_state = S_ERROR;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        next_state = S_FETCH;
      end
      S_MEM_WR: begin
        mem_write = 1'b1;
        iord      = 1'b1;
        if (mem_ready)       next_state = S_FETCH;
        else if (wd_expired) next_state = S_ERROR;
      end
      S_EXEC: begin
        alu_src_a  = 1'b1;
        alu_op     = ALUOP_W'(ALU_RTYPE);
        next_state = S_R_WB;
      end
      S_R_WB: begin
        reg_write  = 1'b1;
        reg_dst    = 1'b1;
        next_state = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = ALUOP_W'(ALU_SUB);
        pc_write_cond = 1'b1;
        pc_source     = 2'd1;
        next_state    = S_FETCH;
      end
      S_JUMP: begin
        pc_write   = 1'b1;
        pc_source  = 2'd2;
        next_state = S_FETCH;
      end
      S_ADDI_EX: begin
        alu_src_a  = 1'b1;
        alu_src_b  = 2'd2;
        alu_op     = ALUOP_W'(ALU_ADD);
        next_state = S_ADDI_WB;
      end
      S_ADDI_WB: begin
        reg_write  = 1'b1;
        next_state = S_FETCH;
      end
      S_ERROR: mem_err = 1'b1;
      default: next_state = S_IDLE;
    endcase
  end

  assign state_o = state;

endmodule
